// File: rtl/bcd_pkg.sv
// Shared BCD constants and a helper that turns a binary constant into packed BCD.
package bcd_pkg;

    localparam int         BCD_W          = 4;
    localparam logic [3:0] BCD_MAX        = 4'd9;
    localparam logic [3:0] BCD_ZERO       = 4'd0;
    localparam int         BCD_MAX_DIGITS = 8;

    // Least significant decade lands in bits [3:0]; callers slice to their width.
    function automatic logic [BCD_W*BCD_MAX_DIGITS-1:0] to_bcd(input int unsigned value);
        logic [BCD_W*BCD_MAX_DIGITS-1:0] r;
        int unsigned v;
        v = value;
        r = '0;
        for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
            r[i*BCD_W +: BCD_W] = BCD_W'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: increment (or decrement when BCD_CNT_DOWN_EN is defined) with
// carry/borrow out, or a forced load of the wrap value at terminal count.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] cur,
    input  logic             ci,
    input  logic             up,
    input  logic             wrap_en,
    input  logic [BCD_W-1:0] wrap_val,
    output logic [BCD_W-1:0] nxt,
    output logic             co
);

`ifndef BCD_CNT_DOWN_EN
    logic unused_up;
    assign unused_up = up;
`endif

    // NOTE: nxt and co get defaults first so every path assigns them and no latch is inferred.
    always_comb begin
        nxt = cur;
        co  = 1'b0;
        if (wrap_en) begin
            nxt = wrap_val;
        end else if (ci) begin
`ifdef BCD_CNT_DOWN_EN
            if (!up) begin
                if (cur == BCD_ZERO) begin
                    nxt = BCD_MAX;
                    co  = 1'b1;
                end else begin
                    nxt = cur - 4'd1;
                end
            end else if (cur == BCD_MAX) begin
                nxt = BCD_ZERO;
                co  = 1'b1;
            end else begin
                nxt = cur + 4'd1;
            end
`else
            if (cur == BCD_MAX) begin
                nxt = BCD_ZERO;
                co  = 1'b1;
            end else begin
                nxt = cur + 4'd1;
            end
`endif
        end
    end

endmodule

// File: rtl/bcd_counter_mod.sv
// Multi-decade BCD counter with programmable modulus, validated load and cascade carry.
// Define BCD_CNT_DOWN_EN to build the down-counting path selected by UP.
module bcd_counter_mod
    import bcd_pkg::*;
#(
    parameter int DIGITS  = 2,
    parameter int MODULUS = 60
) (
    input  logic                CP,
    input  logic                reset_n,
    input  logic                EN,
    input  logic                CLR,
    input  logic                LOAD,
    input  logic [4*DIGITS-1:0] D,
    input  logic                UP,
    output logic [4*DIGITS-1:0] Cnt,
    output logic                CO,
    output logic                LERR
);

    localparam int W = BCD_W * DIGITS;

    if (DIGITS < 1 || DIGITS > BCD_MAX_DIGITS) begin : g_bad_digits
        $error("bcd_counter_mod: DIGITS=%0d out of range", DIGITS);
    end
    if (MODULUS < 2 || MODULUS > 10**DIGITS) begin : g_bad_modulus
        $error("bcd_counter_mod: MODULUS=%0d out of range for DIGITS=%0d", MODULUS, DIGITS);
    end

    localparam logic [BCD_W*BCD_MAX_DIGITS-1:0] LAST_WIDE = to_bcd(MODULUS - 1);
    localparam logic [W-1:0]                    LAST      = LAST_WIDE[W-1:0];

    logic          dir_up;
    logic          terminal;
    logic          wrap;
    logic [W-1:0]  wrap_val;
    logic [W-1:0]  cnt_next;
    logic [DIGITS:0] carry;
    logic          nib_ok;
    logic          load_ok;

`ifdef BCD_CNT_DOWN_EN
    assign dir_up   = UP;
    assign terminal = dir_up ? (Cnt == LAST) : (Cnt == '0);
    assign wrap_val = dir_up ? '0 : LAST;
`else
    logic unused_up;
    assign unused_up = UP;
    assign dir_up    = 1'b1;
    assign terminal  = (Cnt == LAST);
    assign wrap_val  = '0;
`endif

    assign wrap     = EN & terminal;
    assign CO       = EN & ~CLR & ~LOAD & terminal;
    assign carry[0] = EN;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .cur      (Cnt[i*BCD_W +: BCD_W]),
            .ci       (carry[i]),
            .up       (dir_up),
            .wrap_en  (wrap),
            .wrap_val (wrap_val[i*BCD_W +: BCD_W]),
            .nxt      (cnt_next[i*BCD_W +: BCD_W]),
            .co       (carry[i+1])
        );
    end

    logic unused_carry;
    assign unused_carry = carry[DIGITS];

    // With every nibble a legal digit, BCD order matches numeric order, so D is
    // compared against the packed terminal value directly.
    always_comb begin
        nib_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (D[i*BCD_W +: BCD_W] > BCD_MAX) nib_ok = 1'b0;
        end
    end

    assign load_ok = nib_ok && (D <= LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CP or negedge reset_n) begin
        if (!reset_n) begin
            Cnt  <= '0;
            LERR <= 1'b0;
        end else if (CLR) begin
            Cnt  <= '0;
            LERR <= 1'b0;
        end else if (LOAD) begin
            if (load_ok) Cnt <= D;
            LERR <= ~load_ok;
        end else begin
            Cnt  <= cnt_next;
            LERR <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bcd_counter_mod.sv
// Directed bench: table of single-edge vectors on a mod-60 counter, plus
// sequences for wrap, async reset, mod-24 direction and a secs->mins cascade.
module tb_bcd_counter_mod;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    // mod 60 instance
    logic       a_en, a_clr, a_load, a_up;
    logic [7:0] a_d, a_cnt;
    logic       a_co, a_lerr;

    // mod 24 instance
    logic       b_en, b_clr, b_load, b_up;
    logic [7:0] b_d, b_cnt;
    logic       b_co, b_lerr;

    // cascade: seconds feeding minutes
    logic       s_en, s_clr, s_load, m_clr, m_load, c_up;
    logic [7:0] s_d, m_d, s_cnt, m_cnt;
    logic       s_co, m_co, s_lerr, m_lerr;

    bcd_counter_mod #(.DIGITS(2), .MODULUS(60)) u60 (
        .CP(clk), .reset_n(reset_n), .EN(a_en), .CLR(a_clr), .LOAD(a_load),
        .D(a_d), .UP(a_up), .Cnt(a_cnt), .CO(a_co), .LERR(a_lerr));

    bcd_counter_mod #(.DIGITS(2), .MODULUS(24)) u24 (
        .CP(clk), .reset_n(reset_n), .EN(b_en), .CLR(b_clr), .LOAD(b_load),
        .D(b_d), .UP(b_up), .Cnt(b_cnt), .CO(b_co), .LERR(b_lerr));

    bcd_counter_mod #(.DIGITS(2), .MODULUS(60)) u_sec (
        .CP(clk), .reset_n(reset_n), .EN(s_en), .CLR(s_clr), .LOAD(s_load),
        .D(s_d), .UP(c_up), .Cnt(s_cnt), .CO(s_co), .LERR(s_lerr));

    bcd_counter_mod #(.DIGITS(2), .MODULUS(60)) u_min (
        .CP(clk), .reset_n(reset_n), .EN(s_co), .CLR(m_clr), .LOAD(m_load),
        .D(m_d), .UP(c_up), .Cnt(m_cnt), .CO(m_co), .LERR(m_lerr));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    typedef struct {
        logic       clr;
        logic       load;
        logic       en;
        logic [7:0] d;
        logic       exp_co;
        logic [7:0] exp_cnt;
        logic       exp_lerr;
    } vec_t;

    vec_t vecs[20];

    task automatic edge_done();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp;
        int pulses;

        //                clr   load  en    d      co    cnt    lerr
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'h45, 1'b0, 8'h45, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h60, 1'b0, 8'h45, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h46, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h3A, 1'b0, 8'h46, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 8'h59, 1'b0, 8'h59, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h09, 1'b0, 8'h09, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h10, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 8'h45, 1'b0, 8'h00, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h60, 1'b0, 8'h00, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 8'h58, 1'b0, 8'h58, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h59, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 8'h99, 1'b0, 8'h00, 1'b1};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 8'hF0, 1'b0, 8'h00, 1'b1};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h01, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 8'h59, 1'b0, 8'h59, 1'b0};
        vecs[19] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};

        reset_n = 1'b0;
        {a_en, a_clr, a_load} = '0; a_up = 1'b1; a_d = '0;
        {b_en, b_clr, b_load} = '0; b_up = 1'b1; b_d = '0;
        {s_en, s_clr, s_load, m_clr, m_load} = '0; c_up = 1'b1; s_d = '0; m_d = '0;

        repeat (2) @(negedge clk);
        check("reset_cnt", a_cnt, 8'h00);
        check("reset_lerr", a_lerr, 1'b0);
        check("reset_co", a_co, 1'b0);
        reset_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            a_clr = vecs[i].clr; a_load = vecs[i].load; a_en = vecs[i].en; a_d = vecs[i].d;
            #1;
            check($sformatf("vec%0d_co", i), a_co, vecs[i].exp_co);
            edge_done();
            check($sformatf("vec%0d_cnt", i), a_cnt, vecs[i].exp_cnt);
            check($sformatf("vec%0d_lerr", i), a_lerr, vecs[i].exp_lerr);
        end

        // 120 edges of free counting from 00: decade carries and two CO pulses
        @(negedge clk);
        a_clr = 1'b0; a_load = 1'b0; a_en = 1'b1;
        exp = 0;
        pulses = 0;
        for (int i = 0; i < 120; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            if (a_co === 1'b1) pulses++;
            check($sformatf("run%0d_co", i), a_co, (exp == 59));
            edge_done();
            exp = (exp + 1) % 60;
            check($sformatf("run%0d_cnt", i), a_cnt, bcd2(exp));
        end
        check("run_co_pulses", pulses, 2);

        // asynchronous reset between edges at Cnt=37
        @(negedge clk);
        a_en = 1'b0; a_load = 1'b1; a_d = 8'h36;
        edge_done();
        a_load = 1'b0; a_en = 1'b1;
        edge_done();
        check("pre_reset_cnt", a_cnt, 8'h37);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_cnt", a_cnt, 8'h00);
        check("async_reset_lerr", a_lerr, 1'b0);
        edge_done();
        check("held_reset_cnt", a_cnt, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        edge_done();
        check("post_reset_cnt", a_cnt, 8'h01);

        // reset also clears a pending load-reject flag
        @(negedge clk);
        a_en = 1'b0; a_load = 1'b1; a_d = 8'h75;
        edge_done();
        check("reject_lerr", a_lerr, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_lerr_async", a_lerr, 1'b0);
        @(negedge clk);
        a_load = 1'b0;
        reset_n = 1'b1;

        // mod 24 up sequence 00..23,00
        @(negedge clk);
        b_up = 1'b1; b_en = 1'b1;
        exp = 0;
        for (int i = 0; i < 25; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            check($sformatf("m24_%0d_co", i), b_co, (exp == 23));
            edge_done();
            exp = (exp + 1) % 24;
            check($sformatf("m24_%0d_cnt", i), b_cnt, bcd2(exp));
        end

`ifdef BCD_CNT_DOWN_EN
        @(negedge clk);
        b_en = 1'b0; b_load = 1'b1; b_d = 8'h10;
        edge_done();
        @(negedge clk);
        b_load = 1'b0; b_en = 1'b1; b_up = 1'b0;
        #1;
        check("down_10_co", b_co, 1'b0);
        edge_done();
        check("down_10_cnt", b_cnt, 8'h09);
        @(negedge clk);
        b_en = 1'b0; b_load = 1'b1; b_d = 8'h00;
        edge_done();
        @(negedge clk);
        b_load = 1'b0; b_en = 1'b1;
        #1;
        check("down_00_co", b_co, 1'b1);
        edge_done();
        check("down_00_cnt", b_cnt, 8'h23);
        @(negedge clk);
        #1;
        check("down_23_co", b_co, 1'b0);
        edge_done();
        check("down_23_cnt", b_cnt, 8'h22);
`else
        @(negedge clk);
        b_en = 1'b0; b_load = 1'b1; b_d = 8'h23;
        edge_done();
        @(negedge clk);
        b_load = 1'b0; b_en = 1'b1; b_up = 1'b0;
        #1;
        check("upon_23_co", b_co, 1'b1);
        edge_done();
        check("upon_23_cnt", b_cnt, 8'h00);
        @(negedge clk);
        #1;
        check("upon_00_co", b_co, 1'b0);
        edge_done();
        check("upon_00_cnt", b_cnt, 8'h01);
`endif
        @(negedge clk);
        b_en = 1'b0; b_up = 1'b1;

        // cascade 59:59 -> 00:00, then only seconds advance
        s_load = 1'b1; s_d = 8'h59; m_load = 1'b1; m_d = 8'h59;
        edge_done();
        @(negedge clk);
        s_load = 1'b0; m_load = 1'b0; s_en = 1'b1;
        #1;
        check("casc_sec_co", s_co, 1'b1);
        check("casc_min_co", m_co, 1'b1);
        edge_done();
        check("casc_sec_wrap", s_cnt, 8'h00);
        check("casc_min_wrap", m_cnt, 8'h00);
        @(negedge clk);
        #1;
        check("casc_sec_co2", s_co, 1'b0);
        edge_done();
        check("casc_sec_01", s_cnt, 8'h01);
        check("casc_min_hold", m_cnt, 8'h00);

        // EN=0 at 59:12 holds both stages with no carry
        @(negedge clk);
        s_en = 1'b0; s_load = 1'b1; s_d = 8'h59; m_load = 1'b1; m_d = 8'h12;
        edge_done();
        @(negedge clk);
        s_load = 1'b0; m_load = 1'b0;
        #1;
        check("casc_idle_sec_co", s_co, 1'b0);
        check("casc_idle_min_co", m_co, 1'b0);
        edge_done();
        check("casc_idle_sec", s_cnt, 8'h59);
        check("casc_idle_min", m_cnt, 8'h12);
        @(negedge clk);
        s_en = 1'b1;
        edge_done();
        check("casc_adv_sec", s_cnt, 8'h00);
        check("casc_adv_min", m_cnt, 8'h13);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bcd_counter_mod.md
Name: bcd_counter_mod

Overview:
- Parametrised multi-digit BCD counter with programmable modulus.
- Successor to the single-decade mod-10 counter.
- Used for seconds/minutes (mod 60) and hours (mod 24) in the digital clock; instances cascade through EN/CO.
- Adds: arbitrary modulus, multiple digits, synchronous clear, validated parallel load for time setting, carry-out, and optional down-counting.

Parameters:
- DIGITS, 2, number of BCD decades; output width is 4*DIGITS.
- MODULUS, 60, count range 0..MODULUS-1. Legal range is 2 <= MODULUS <= 10**DIGITS; illegal values are caught by an elaboration-time check.

Ports:
- CP  input  1  clock, rising-edge active.
- reset_n  input  1  asynchronous active-low reset.
- EN  input  1  count enable; this is the carry-in when cascading.
- CLR  input  1  synchronous clear to zero.
- LOAD  input  1  synchronous parallel load strobe.
- D  input  4*DIGITS  load value, BCD, least significant decade in D[3:0].
- UP  input  1  direction: 1 = up, 0 = down. Only honoured when BCD_CNT_DOWN_EN is defined.
- Cnt  output  4*DIGITS  current count, BCD.
- CO  output  1  combinational terminal-count carry to the next stage.
- LERR  output  1  registered one-cycle load-reject flag.

Behaviour:
- Reset: reset_n=0 asynchronously forces Cnt=0 and LERR=0. Operation resumes on the first CP rising edge after reset_n rises. Reset asserted mid-count or mid-load always wins.
- Per-edge priority: CLR > LOAD > EN > hold.
- CLR=1: Cnt<=0, LERR<=0. A simultaneous LOAD is ignored and LERR is not set.
- LOAD=1 (and CLR=0), D accepted: every nibble <=9 and value(D) < MODULUS. Result: Cnt<=D, LERR<=0.
- LOAD=1 (and CLR=0), D rejected: Cnt holds, LERR<=1 for exactly one cycle. EN is ignored in a LOAD cycle either way.
- EN=1, no CLR/LOAD, up direction:
  - Cnt==MODULUS-1 -> 0.
  - Otherwise BCD increment: a nibble at 9 wraps to 0 and carries into the next nibble.
- EN=1, no CLR/LOAD, down direction:
  - Cnt==0 -> MODULUS-1, in BCD.
  - Otherwise BCD decrement: a nibble at 0 becomes 9 and borrows from the next nibble.
- EN=0: Cnt holds.
- LERR: returns to 0 on any edge without a rejected load.
- Latency: Cnt updates one edge after the qualifying inputs; no pipeline.
- CO = EN & ~CLR & ~LOAD & terminal, where terminal is Cnt==MODULUS-1 in up mode and Cnt==0 in down mode.
  - Purely combinational from registered Cnt and live inputs.
  - Cascade by wiring CO to the next stage's EN, all stages on a common CP. The chain ripples within one cycle.
- Wrap-around is exact at MODULUS; the count never holds a value >= MODULUS, and nibbles never hold 10-15.
- Cascade example: with MODULUS=24, DIGITS=2, Cnt sequence is 00..09,10..19,20..23,00.

Optional Feature:
- Macro: BCD_CNT_DOWN_EN.
- Defined: UP selects direction as above; the down-mode terminal and wrap logic are built.
- Undefined: the UP port exists but is ignored, the counter is up-only, and CO terminal is always Cnt==MODULUS-1. No decrement logic is synthesised.

Decomposition:
- Shared package / include (bcd_pkg): BCD_W=4, BCD_MAX=4'd9, BCD_ZERO=4'd0, and a function converting MODULUS-1 into its packed BCD constant.
- Sub-module bcd_digit: one decade cell.
  - Inputs: ci (carry/borrow in), up, wrap_en.
  - Outputs: next nibble and co.
  - Instantiated DIGITS times via generate.
- Top level owns the modulus compare, load validation, CLR/LOAD priority, and LERR register.

Test Plan:
- Reset: drive reset_n=0 mid-count at Cnt=37 asynchronously between edges -> Cnt=00 and LERR=0 immediately; counting restarts from 00 after release.
- Up wrap, MODULUS=60, EN=1 held: 58 -> 59 with CO=1 during 59 -> 00; 09 -> 10 decade carry verified; 120 edges give two CO pulses.
- Load: D=8'h45 accepted -> Cnt=45, LERR=0. D=8'h60 rejected -> Cnt holds, LERR=1 for one cycle. D=8'h3A rejected -> LERR=1. CLR with LOAD same edge -> Cnt=00, LERR=0.
- Down mode (macro defined), MODULUS=24, UP=0: 10 -> 09, 00 -> 23 with CO=1 during 00. Macro undefined, UP=0 -> still counts up.
- Cascade: secs (mod 60) CO -> mins EN. Start at 59:59 with the top stage mod 60 -> 00:00 next edge; mins only advances on secs wrap. EN=0 holds both stages and CO=0.
